// File: rtl/multicycle_ctrl_fsm_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_ctrl_fsm_if : controller <-> CHARIS datapath signal bundle    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface multicycle_ctrl_fsm_if #(
    parameter int INSTR_W = 32,
    parameter int CNT_W   = 16
);
    logic [INSTR_W-1:0] Instr;
    logic               Instr_Valid;
    logic               Zero;
    logic               PC_Sel;
    logic               PC_LdEn;
    logic               RF_B_sel;
    logic               RF_WrData_sel;
    logic               RF_WEn;
    logic               ALU_Bin_sel;
    logic [3:0]         ALU_func;
    logic               MEM_WrEn;
    logic               Mem_In_Out_Sel;
    logic               Busy;
    logic               Illegal_Op;
    logic [CNT_W-1:0]   Retired;

    modport master (
        input  Instr, Instr_Valid, Zero,
        output PC_Sel, PC_LdEn, RF_B_sel, RF_WrData_sel, RF_WEn, ALU_Bin_sel,
               ALU_func, MEM_WrEn, Mem_In_Out_Sel, Busy, Illegal_Op, Retired
    );

    modport slave (
        output Instr, Instr_Valid, Zero,
        input  PC_Sel, PC_LdEn, RF_B_sel, RF_WrData_sel, RF_WEn, ALU_Bin_sel,
               ALU_func, MEM_WrEn, Mem_In_Out_Sel, Busy, Illegal_Op, Retired
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_ctrl_fsm : multicycle control unit with per-class state paths |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module multicycle_ctrl_fsm #(
    parameter int INSTR_W   = 32,
    parameter int EX_CYCLES = 1,
    parameter int MEM_LAT   = 1,
    parameter int CNT_W     = 16
) (
    input  wire logic             Clk,
    input  wire logic             Reset,
    multicycle_ctrl_fsm_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_PCUPD  = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        C_NOP = 4'd0, C_B = 4'd1, C_ILL = 4'd2, C_RTYPE = 4'd3, C_ADDI = 4'd4,
        C_ANDI = 4'd5, C_ORI = 4'd6, C_BEQ = 4'd7, C_BNE = 4'd8, C_LW = 4'd9,
        C_LB = 4'd10, C_SW = 4'd11, C_SB = 4'd12
    } iclass_t;

    typedef struct packed {
        logic       pc_sel;
        logic       pc_lden;
        logic       rf_b_sel;
        logic       rf_wrdata_sel;
        logic       rf_wen;
        logic       alu_bin_sel;
        logic [3:0] alu_func;
        logic       mem_wren;
        logic       mem_sel;
        logic       busy;
        logic       illegal;
    } ctrl_t;

    localparam logic [3:0] c_EX_LAST  = 4'(EX_CYCLES - 1);
    localparam logic [3:0] c_MEM_LAST = 4'(MEM_LAT - 1);

    function automatic iclass_t classify(input logic [INSTR_W-1:0] ir);
        iclass_t c;
        if (ir == '0) begin
            c = C_NOP;
        end else begin
            case (ir[INSTR_W-1 -: 6])
                6'b111111:                   c = C_B;
                6'b100000:                   c = C_RTYPE;
                6'b111000, 6'b111001,
                6'b110000:                   c = C_ADDI;
                6'b110010:                   c = C_ANDI;
                6'b110011:                   c = C_ORI;
                6'b000000:                   c = C_BEQ;
                6'b000001:                   c = C_BNE;
                6'b001111:                   c = C_LW;
                6'b000011:                   c = C_LB;
                6'b011111:                   c = C_SW;
                6'b000111:                   c = C_SB;
                default:                     c = C_ILL;
            endcase
        end
        return c;
    endfunction

    // ALU/operand controls used in EXEC and held through MEM/WB
    function automatic ctrl_t alu_ctrl(input iclass_t c, input logic [3:0] func);
        ctrl_t k;
        k = '0;
        case (c)
            C_RTYPE:      k.alu_func = func;
            C_ADDI:       k.alu_bin_sel = 1'b1;
            C_ANDI:       begin k.alu_bin_sel = 1'b1; k.alu_func = 4'b0010; end
            C_ORI:        begin k.alu_bin_sel = 1'b1; k.alu_func = 4'b0011; end
            C_BEQ, C_BNE: begin k.rf_b_sel = 1'b1; k.alu_func = 4'b0001; end
            C_LW, C_LB:   k.alu_bin_sel = 1'b1;
            C_SW, C_SB:   begin k.alu_bin_sel = 1'b1; k.rf_b_sel = 1'b1; end
            default:      k = '0;
        endcase
        return k;
    endfunction

    state_t             state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               taken_q, taken_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    ctrl_t              ctrl_q, ctrl_d;
    iclass_t            w_cls_q, w_cls_d;
    ctrl_t              w_alu;
    logic               w_is_load, w_is_store, w_is_byte;

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        taken_d   = taken_q;
        cnt_d     = '0;
        retired_d = retired_q;
        w_cls_q   = classify(ir_q);

        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: begin
                if (bus.Instr_Valid) begin
                    ir_d    = bus.Instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (w_cls_q == C_NOP || w_cls_q == C_B || w_cls_q == C_ILL)
                    state_d = S_PCUPD;
                else
                    state_d = S_EXEC;
            end
            S_EXEC: begin
                if (cnt_q != c_EX_LAST) begin
                    cnt_d = cnt_q + 4'd1;
                end else if (w_cls_q == C_BEQ || w_cls_q == C_BNE) begin
                    taken_d = (w_cls_q == C_BEQ) ? bus.Zero : ~bus.Zero;
                    state_d = S_PCUPD;
                end else if (w_cls_q inside {C_LW, C_LB, C_SW, C_SB}) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (cnt_q != c_MEM_LAST)
                    cnt_d = cnt_q + 4'd1;
                else
                    state_d = (w_cls_q == C_SW || w_cls_q == C_SB) ? S_PCUPD : S_WB;
            end
            S_WB:    state_d = S_PCUPD;
            S_PCUPD: begin
                state_d   = S_FETCH;
                retired_d = retired_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next register contents so they land
        // in flops aligned with the state they belong to.
        w_cls_d    = classify(ir_d);
        w_alu      = alu_ctrl(w_cls_d, ir_d[3:0]);
        w_is_load  = (w_cls_d == C_LW || w_cls_d == C_LB);
        w_is_store = (w_cls_d == C_SW || w_cls_d == C_SB);
        w_is_byte  = (w_cls_d == C_LB || w_cls_d == C_SB);
        ctrl_d     = '0;
        case (state_d)
            S_DECODE: ctrl_d.illegal = (w_cls_d == C_ILL);
            S_EXEC:   ctrl_d = w_alu;
            S_MEM: begin
                ctrl_d          = w_alu;
                ctrl_d.mem_sel  = w_is_byte;
                ctrl_d.mem_wren = w_is_store && (cnt_d == c_MEM_LAST);
            end
            S_WB: begin
                if (w_is_load) begin
                    ctrl_d.rf_wrdata_sel = 1'b1;
                    ctrl_d.mem_sel       = w_is_byte;
                end else begin
                    ctrl_d = w_alu;
                end
                ctrl_d.rf_wen = 1'b1;
            end
            S_PCUPD: begin
                ctrl_d.pc_lden = 1'b1;
                ctrl_d.pc_sel  = (w_cls_d == C_B) ||
                                 ((w_cls_d == C_BEQ || w_cls_d == C_BNE) && taken_d);
            end
            default: ctrl_d = '0;
        endcase
        ctrl_d.busy = (state_d != S_IDLE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            ir_q      <= '0;
            taken_q   <= 1'b0;
            cnt_q     <= '0;
            retired_q <= '0;
            ctrl_q    <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            taken_q   <= taken_d;
            cnt_q     <= cnt_d;
            retired_q <= retired_d;
            ctrl_q    <= ctrl_d;
        end
    end

    assign bus.PC_Sel         = ctrl_q.pc_sel;
    assign bus.PC_LdEn        = ctrl_q.pc_lden;
    assign bus.RF_B_sel       = ctrl_q.rf_b_sel;
    assign bus.RF_WrData_sel  = ctrl_q.rf_wrdata_sel;
    assign bus.RF_WEn         = ctrl_q.rf_wen;
    assign bus.ALU_Bin_sel    = ctrl_q.alu_bin_sel;
    assign bus.ALU_func       = ctrl_q.alu_func;
    assign bus.MEM_WrEn       = ctrl_q.mem_wren;
    assign bus.Mem_In_Out_Sel = ctrl_q.mem_sel;
    assign bus.Busy           = ctrl_q.busy;
    assign bus.Illegal_Op     = ctrl_q.illegal;
    assign bus.Retired        = retired_q;
endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_multicycle_ctrl_fsm : bench for two parameterisations of the FSM      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_multicycle_ctrl_fsm;
    localparam int EXA = 1, MLA = 1, CWA = 16;
    localparam int EXB = 2, MLB = 3, CWB = 4;

    typedef struct packed {
        logic       pc_sel;
        logic       pc_lden;
        logic       rf_b_sel;
        logic       rf_wrdata_sel;
        logic       rf_wen;
        logic       alu_bin_sel;
        logic [3:0] alu_func;
        logic       mem_wren;
        logic       mem_sel;
        logic       busy;
        logic       illegal;
    } out_t;

    typedef struct {
        logic        sel;
        logic [31:0] instr;
        logic        zv;
        int          wt;
        int          cyc;
        logic        pcs;
        int          nrf;
        int          nmem;
        int          nill;
    } tv_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        valid, zero, sel;
    int          n_tests = 0, n_fail = 0;
    out_t        obs;
    logic [31:0] ret_obs, exp_ret;
    out_t        exp_q[$];
    tv_t         tv[14];

    multicycle_ctrl_fsm_if #(.INSTR_W(32), .CNT_W(CWA)) ifa();
    multicycle_ctrl_fsm_if #(.INSTR_W(32), .CNT_W(CWB)) ifb();

    assign ifa.Instr = instr;  assign ifa.Instr_Valid = valid;  assign ifa.Zero = zero;
    assign ifb.Instr = instr;  assign ifb.Instr_Valid = valid;  assign ifb.Zero = zero;

    multicycle_ctrl_fsm #(.INSTR_W(32), .EX_CYCLES(EXA), .MEM_LAT(MLA), .CNT_W(CWA))
        dut_a (.Clk(clk), .Reset(rst), .bus(ifa));
    multicycle_ctrl_fsm #(.INSTR_W(32), .EX_CYCLES(EXB), .MEM_LAT(MLB), .CNT_W(CWB))
        dut_b (.Clk(clk), .Reset(rst), .bus(ifb));

    always #5 clk = ~clk;

    always_comb begin
        if (sel) begin
            obs = {ifb.PC_Sel, ifb.PC_LdEn, ifb.RF_B_sel, ifb.RF_WrData_sel, ifb.RF_WEn,
                   ifb.ALU_Bin_sel, ifb.ALU_func, ifb.MEM_WrEn, ifb.Mem_In_Out_Sel,
                   ifb.Busy, ifb.Illegal_Op};
            ret_obs = {28'd0, ifb.Retired};
        end else begin
            obs = {ifa.PC_Sel, ifa.PC_LdEn, ifa.RF_B_sel, ifa.RF_WrData_sel, ifa.RF_WEn,
                   ifa.ALU_Bin_sel, ifa.ALU_func, ifa.MEM_WrEn, ifa.Mem_In_Out_Sel,
                   ifa.Busy, ifa.Illegal_Op};
            ret_obs = {16'd0, ifa.Retired};
        end
    end

    function automatic out_t fetch_vec();
        out_t o;
        o = '0;
        o.busy = 1'b1;
        return o;
    endfunction

    // Reference: expected per-cycle outputs from DECODE through PCUPD
    function automatic void build_trace(input logic [31:0] ins, input logic zv,
                                        input int ex, input int ml);
        logic [5:0] op;
        bit   nop, is_b, beq, bne, is_r, ld, st, byt, legal;
        out_t base, o;
        op    = ins[31:26];
        nop   = (ins == 32'd0);
        is_b  = (op == 6'b111111);
        beq   = !nop && (op == 6'b000000);
        bne   = (op == 6'b000001);
        is_r  = (op == 6'b100000);
        ld    = (op == 6'b001111) || (op == 6'b000011);
        st    = (op == 6'b011111) || (op == 6'b000111);
        byt   = (op == 6'b000011) || (op == 6'b000111);
        base  = '0;
        base.busy = 1'b1;
        legal = 1'b1;
        case (op)
            6'b100000: base.alu_func = ins[3:0];
            6'b111000, 6'b111001, 6'b110000: base.alu_bin_sel = 1'b1;
            6'b110010: begin base.alu_bin_sel = 1'b1; base.alu_func = 4'b0010; end
            6'b110011: begin base.alu_bin_sel = 1'b1; base.alu_func = 4'b0011; end
            6'b000000, 6'b000001: begin base.rf_b_sel = 1'b1; base.alu_func = 4'b0001; end
            6'b001111, 6'b000011: base.alu_bin_sel = 1'b1;
            6'b011111, 6'b000111: begin base.alu_bin_sel = 1'b1; base.rf_b_sel = 1'b1; end
            6'b111111: ;
            default: legal = 1'b0;
        endcase
        if (nop) legal = 1'b1;
        exp_q.delete();
        o = fetch_vec();
        o.illegal = !legal;
        exp_q.push_back(o);
        if (!nop && !is_b && legal) begin
            for (int e = 0; e < ex; e++) exp_q.push_back(base);
            if (ld || st) begin
                for (int m = 0; m < ml; m++) begin
                    o = base;
                    o.mem_sel  = byt;
                    o.mem_wren = st && (m == ml - 1);
                    exp_q.push_back(o);
                end
            end
            if (!st && !beq && !bne) begin
                o = ld ? fetch_vec() : base;
                o.rf_wen = 1'b1;
                if (ld) begin o.rf_wrdata_sel = 1'b1; o.mem_sel = byt; end
                exp_q.push_back(o);
            end
        end
        o = fetch_vec();
        o.pc_lden = 1'b1;
        o.pc_sel  = is_b || (beq && zv) || (bne && !zv);
        exp_q.push_back(o);
        if (is_r) o = o;
    endfunction

    task automatic check_out(input string nm, input int idx, input out_t act, input out_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_ret(input string nm, input logic [31:0] exp);
        n_tests++;
        if (ret_obs !== exp) begin
            n_fail++;
            $display("FAIL %s: Retired got %0d expected %0d", nm, ret_obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; valid = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        check_out("reset_outs", 0, obs, '0);
        check_ret("reset_retired", 32'd0);
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        check_out("post_reset_fetch", 0, obs, fetch_vec());
        exp_ret = 32'd0;
    endtask

    // Issues one instruction from FETCH and follows it back to FETCH
    task automatic run_instr(input logic [31:0] ins, input logic zv, input int wt,
                             output int cyc, output logic pcs, output int nrf,
                             output int nmem, output int nill);
        int ex, ml;
        ex = sel ? EXB : EXA;
        ml = sel ? MLB : MLA;
        build_trace(ins, zv, ex, ml);
        cyc = 0; pcs = 1'b0; nrf = 0; nmem = 0; nill = 0;
        valid = 1'b0;
        for (int k = 0; k < wt; k++) begin
            instr = $urandom;
            check_out("fetch_wait", k, obs, fetch_vec());
            @(posedge clk); @(negedge clk);
        end
        instr = ins; valid = 1'b1; zero = zv;
        check_out("fetch", 0, obs, fetch_vec());
        @(posedge clk); @(negedge clk);
        valid = 1'b0;
        instr = $urandom;
        for (int i = 0; i < exp_q.size(); i++) begin
            zero = (i <= ex) ? zv : ((i % 2 == 1) ? ~zv : zv);
            check_out("trace", i, obs, exp_q[i]);
            if (obs.pc_lden && cyc == 0) begin cyc = i + 2; pcs = obs.pc_sel; end
            if (obs.rf_wen)   nrf++;
            if (obs.mem_wren) nmem++;
            if (obs.illegal)  nill++;
            @(posedge clk); @(negedge clk);
        end
        check_out("refetch", 0, obs, fetch_vec());
        exp_ret = (exp_ret + 32'd1) & (sel ? 32'hF : 32'hFFFF);
        check_ret("retired", exp_ret);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          cyc, nrf, nmem, nill, saw;
        logic        pcs;
        logic [5:0]  ops[16];
        logic [31:0] ins;
        int          p;

        //            sel  instr         zv  wt cyc pcs rf mem ill
        tv[0]  = '{1'b0, 32'h8000_0001, 1'b0, 0, 5, 1'b0, 1, 0, 0};
        tv[1]  = '{1'b0, 32'h0000_0004, 1'b1, 0, 4, 1'b1, 0, 0, 0};
        tv[2]  = '{1'b0, 32'h0000_0004, 1'b0, 1, 4, 1'b0, 0, 0, 0};
        tv[3]  = '{1'b0, 32'h0400_0008, 1'b0, 0, 4, 1'b1, 0, 0, 0};
        tv[4]  = '{1'b0, 32'hFC00_0000, 1'b0, 4, 3, 1'b1, 0, 0, 0};
        tv[5]  = '{1'b0, 32'h0000_0000, 1'b1, 0, 3, 1'b0, 0, 0, 0};
        tv[6]  = '{1'b0, 32'hA800_0000, 1'b0, 0, 3, 1'b0, 0, 0, 1};
        tv[7]  = '{1'b0, 32'hC000_0005, 1'b0, 0, 5, 1'b0, 1, 0, 0};
        tv[8]  = '{1'b0, 32'h3C00_0000, 1'b0, 2, 6, 1'b0, 1, 0, 0};
        tv[9]  = '{1'b0, 32'h7C00_0000, 1'b0, 0, 5, 1'b0, 0, 1, 0};
        tv[10] = '{1'b1, 32'h1C00_0000, 1'b0, 0, 8, 1'b0, 0, 1, 0};
        tv[11] = '{1'b1, 32'h3C00_0010, 1'b0, 0, 9, 1'b0, 1, 0, 0};
        tv[12] = '{1'b1, 32'hCC00_0000, 1'b1, 0, 6, 1'b0, 1, 0, 0};
        tv[13] = '{1'b1, 32'h0000_0004, 1'b1, 0, 5, 1'b1, 0, 0, 0};

        ops = '{6'b111111, 6'b100000, 6'b111000, 6'b111001, 6'b110000, 6'b110010,
                6'b110011, 6'b000000, 6'b000001, 6'b001111, 6'b000011, 6'b011111,
                6'b000111, 6'b101010, 6'b010101, 6'b000000};

        rst = 1'b1; valid = 1'b0; zero = 1'b0; instr = '0; sel = 1'b0; exp_ret = '0;
        do_reset();

        for (int i = 0; i < 14; i++) begin
            if (tv[i].sel != sel) begin
                sel = tv[i].sel;
                do_reset();
            end
            run_instr(tv[i].instr, tv[i].zv, tv[i].wt, cyc, pcs, nrf, nmem, nill);
            check_int($sformatf("vec%0d_cycles", i), cyc, tv[i].cyc);
            check_int($sformatf("vec%0d_pc_sel", i), int'(pcs), int'(tv[i].pcs));
            check_int($sformatf("vec%0d_rf_writes", i), nrf, tv[i].nrf);
            check_int($sformatf("vec%0d_mem_writes", i), nmem, tv[i].nmem);
            check_int($sformatf("vec%0d_illegal", i), nill, tv[i].nill);
        end

        // Reset held two cycles while an add sits in EXEC (sel=1, EX_CYCLES=2)
        saw = 0;
        instr = 32'h8000_0000; valid = 1'b1;
        @(posedge clk); @(negedge clk);
        valid = 1'b0;
        @(posedge clk); @(negedge clk);
        check_int("add_in_exec_bin_sel", int'(obs.alu_bin_sel), 0);
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk); @(negedge clk);
            if (obs.rf_wen) saw = 1;
        end
        check_out("rst_mid_exec_outs", 0, obs, '0);
        check_ret("rst_mid_exec_retired", 32'd0);
        rst = 1'b0;
        repeat (6) begin
            @(posedge clk); @(negedge clk);
            if (obs.rf_wen || obs.pc_lden) saw = 1;
        end
        check_int("rst_mid_exec_no_wb", saw, 0);
        check_out("rst_mid_exec_fetch", 0, obs, fetch_vec());
        exp_ret = 32'd0;

        // Four-bit counter wraps after 16 nops
        for (int k = 0; k < 16; k++)
            run_instr(32'd0, 1'b0, 0, cyc, pcs, nrf, nmem, nill);
        check_ret("wrap_to_zero", 32'd0);

        // Randomised instructions against the reference trace
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            do_reset();
            for (int n = 0; n < 30; n++) begin
                p   = $urandom_range(0, 15);
                ins = {ops[p], 26'($urandom)};
                if (p == 15) ins = 32'd0;
                run_instr(ins, 1'($urandom), $urandom_range(0, 2), cyc, pcs, nrf, nmem, nill);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Parametrised multicycle control unit for the CHARIS datapath (IFSTAGE, DECSTAGE, ALU, MEMSTAGE). It supersedes the free-running phase-counter controller.
- It runs an explicit state machine with per-class paths, a configurable execute and memory latency, and a fetch handshake.
- It latches the instruction internally, so decoded controls never glitch mid-instruction.
- It flags illegal opcodes and counts retired instructions.

Parameters:
- INSTR_W, 32: instruction width; opcode is Instr[INSTR_W-1:INSTR_W-6], func is Instr[3:0].
- EX_CYCLES, 1: cycles spent in EXEC (1..8); models a slower ALU.
- MEM_LAT, 1: cycles spent in MEM (1..8); models memory latency.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- Clk  in  1  clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Instr  in  INSTR_W  instruction word from instruction memory.
- Instr_Valid  in  1  Instr is valid this cycle.
- Zero  in  1  ALU zero flag.
- PC_Sel  out  1  0 = PC+4, 1 = branch target.
- PC_LdEn  out  1  PC load pulse.
- RF_B_sel  out  1  RF read port B selects rd (beq/bne/sw/sb).
- RF_WrData_sel  out  1  0 = ALU result, 1 = memory data.
- RF_WEn  out  1  register file write enable.
- ALU_Bin_sel  out  1  0 = RF B, 1 = immediate.
- ALU_func  out  4  0000 add, 0001 sub, 0010 and, 0011 or; R-type passes func.
- MEM_WrEn  out  1  data memory write enable.
- Mem_In_Out_Sel  out  1  0 = word, 1 = byte (zero-extended).
- Busy  out  1  high in every state except IDLE.
- Illegal_Op  out  1  one-cycle pulse when an unknown opcode is decoded.
- Retired  out  CNT_W  count of completed instructions; wraps modulo 2^CNT_W.

Behaviour:
- Reset (synchronous, when Reset=1 at a rising edge):
  - State goes to IDLE and the IR and internal counters clear.
  - Retired=0 and all outputs are 0.
  - Reset overrides any in-flight instruction; that instruction is not retired and causes no PC, RF or memory write after the edge.
- Outputs are decoded only from the state register, the latched IR and the latched taken flag. There is no combinational path from Instr or Zero to any output.
- States are IDLE, FETCH, DECODE, EXEC, MEM, WB, PCUPD.
- IDLE and FETCH:
  - IDLE moves to FETCH after one cycle.
  - FETCH waits while Instr_Valid=0. When Instr_Valid=1, IR<=Instr and the next state is DECODE.
- DECODE: class from IR opcode decides the next state.
  - nop (IR==0) or b (111111): PCUPD.
  - Illegal opcode: Illegal_Op=1 for this cycle, then PCUPD with PC_Sel=0, so the instruction is skipped.
  - All other legal opcodes: EXEC.
- EXEC: lasts EX_CYCLES cycles, tracked by an internal counter.
  - R-type (100000): ALU_func=IR[3:0], ALU_Bin_sel=0.
  - li/lui/addi (111000/111001/110000): ALU_Bin_sel=1, ALU_func=0000.
  - andi (110010): ALU_Bin_sel=1, ALU_func=0010.
  - ori (110011): ALU_Bin_sel=1, ALU_func=0011.
  - beq (000000) / bne (000001): RF_B_sel=1, ALU_func=0001.
  - lw/lb/sw/sb: ALU_Bin_sel=1, ALU_func=0000; sw/sb also RF_B_sel=1.
- EXEC exit:
  - On the last EXEC cycle, branches latch taken=Zero (beq) or ~Zero (bne).
  - Next state: branches go to PCUPD, memory ops to MEM, all others to WB.
- MEM: lasts MEM_LAT cycles.
  - EXEC address controls (ALU_Bin_sel, ALU_func, RF_B_sel) are held.
  - Mem_In_Out_Sel=1 for lb/sb.
  - sw/sb: MEM_WrEn=1 only in the final MEM cycle (single write), then PCUPD.
  - lw/lb: then WB.
- WB: one cycle with RF_WEn=1.
  - Loads: RF_WrData_sel=1, Mem_In_Out_Sel held.
  - ALU-class: RF_WrData_sel=0, with EXEC ALU controls held.
- PCUPD: one cycle.
  - PC_LdEn=1.
  - PC_Sel=1 for b, or for a taken beq/bne; otherwise 0.
  - Retired increments, including for nop and illegal opcodes.
  - Next state is FETCH.
- Default rule: any output not listed for a state is 0.
- Total cycles per instruction, excluding FETCH wait:
  - nop/b/illegal: 3.
  - beq/bne: 3+EX_CYCLES.
  - ALU-class: 4+EX_CYCLES.
  - sw/sb: 3+EX_CYCLES+MEM_LAT.
  - lw/lb: 4+EX_CYCLES+MEM_LAT.
- An Instr change outside FETCH has no effect on outputs.

Test Plan:
- Reset held 2 cycles mid-EXEC of add -> next cycle all outputs 0, Busy=0, Retired=0, RF_WEn never asserted for that add.
- Defaults, R-type 0x8000_0001 (sub) with Instr_Valid=1 -> ALU_func=0001 in EXEC, RF_WEn=1 in exactly 1 cycle, PC_LdEn=1 with PC_Sel=0 at cycle 5 after FETCH, Retired=1.
- beq with Zero=1, then beq with Zero=0 -> PC_Sel=1 in PCUPD for the first, 0 for the second. Toggling Zero during PCUPD does not change PC_Sel.
- MEM_LAT=3, sb -> MEM_WrEn high exactly 1 cycle (3rd MEM cycle) with Mem_In_Out_Sel=1 and RF_B_sel=1. lw with MEM_LAT=3 -> WB at cycle 3+EX_CYCLES+MEM_LAT, RF_WrData_sel=1.
- Instr_Valid held 0 for 4 cycles -> state stays FETCH, all strobes 0, Busy=1. Instr 0xFC00_0000 (b) -> PC_Sel=1 and PC_LdEn=1 two cycles after capture.
- Opcode 101010 -> Illegal_Op pulse 1 cycle, no RF or memory write, PC_Sel=0, Retired increments. CNT_W=4 with 16 nops -> Retired wraps to 0.
